// File: rtl/map_event_unit_pkg.sv
// Shared definitions for the map event unit: map geometry, tile IDs,
// event codes, FSM encoding and the cell-address helper.
package map_event_unit_pkg;

    localparam int MAP_WIDTH  = 11;
    localparam int MAP_HEIGHT = 11;

    localparam logic [15:0] TILE_FLOOR = 16'h0000;
    localparam logic [15:0] TILE_WALL  = 16'h0001;
    localparam logic [15:0] TILE_KEY   = 16'h0002;
    localparam logic [15:0] TILE_DOOR  = 16'h0003;
    localparam logic [15:0] TILE_STAIR = 16'h0004;

    typedef enum logic [2:0] {
        EVT_FLOOR       = 3'd0,
        EVT_BLOCKED     = 3'd1,
        EVT_KEY         = 3'd2,
        EVT_DOOR_OPEN   = 3'd3,
        EVT_DOOR_LOCKED = 3'd4,
        EVT_STAIR       = 3'd5
    } evt_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_DATA  = 3'd2,
        S_WRITE = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    function automatic logic [18:0] map_addr(input logic [3:0] x, input logic [3:0] y);
        return (19'(y) * 19'(MAP_WIDTH)) + 19'(x);
    endfunction

endpackage

// File: rtl/map_event_unit_tile_decode.sv
// Combinational tile classifier: maps a tile ID plus the current key count
// to an event, the accept decision, a write-back request and a key delta.
module map_tile_decode
    import map_event_unit_pkg::*;
(
    input  logic [15:0]       i_tile,
    input  logic [3:0]        i_key_count,
    output evt_t              o_evt,
    output logic              o_accept,
    output logic              o_do_write,
    output logic signed [1:0] o_key_delta
);

    // Classify the tile; unknown IDs fall through to BLOCKED.
    always_comb begin
        o_evt       = EVT_BLOCKED;
        o_accept    = 1'b0;
        o_do_write  = 1'b0;
        o_key_delta = 2'sd0;
        case (i_tile)
            TILE_FLOOR: begin
                o_evt    = EVT_FLOOR;
                o_accept = 1'b1;
            end
            TILE_STAIR: begin
                o_evt    = EVT_STAIR;
                o_accept = 1'b1;
            end
            TILE_KEY: begin
                o_evt       = EVT_KEY;
                o_accept    = 1'b1;
                o_do_write  = 1'b1;
                o_key_delta = 2'sd1;
            end
            TILE_DOOR: begin
                if (i_key_count != 4'd0) begin
                    o_evt       = EVT_DOOR_OPEN;
                    o_do_write  = 1'b1;
                    o_key_delta = -2'sd1;
                end else begin
                    o_evt = EVT_DOOR_LOCKED;
                end
            end
            default: begin
                o_evt = EVT_BLOCKED;
            end
        endcase
    end

endmodule

// File: rtl/map_event_unit.sv
// Resolves player move requests against the tile map through RAM port B,
// maintaining the key inventory and clearing consumed keys / opened doors.
module map_event_unit
    import map_event_unit_pkg::*;
(
    input  logic        clk,
    input  logic        sys_rst,
    input  logic        req_valid,
    input  logic [3:0]  req_x,
    input  logic [3:0]  req_y,
    output logic        req_ready,
    output logic [18:0] ram_addr,
    output logic        ram_we,
    output logic [15:0] ram_din,
    input  logic [15:0] ram_dout,
    output logic        resp_valid,
    output logic        resp_accept,
    output logic [3:0]  resp_x,
    output logic [3:0]  resp_y,
    output logic [2:0]  resp_evt,
    output logic        stair_pulse,
    output logic [3:0]  key_count
);

    state_t      r_state;
    logic [3:0]  r_req_x, r_req_y;
    evt_t        r_evt;
    logic        r_accept;
    logic [18:0] r_ram_addr;
    logic        r_ram_we;
    logic [15:0] r_ram_din;
    logic        r_resp_valid, r_resp_accept, r_stair_pulse, r_req_ready;
    logic [3:0]  r_resp_x, r_resp_y, r_key_count;
    evt_t        r_resp_evt;

    evt_t              w_evt;
    logic              w_accept, w_do_write, w_oob;
    logic signed [1:0] w_key_delta;
    logic [3:0]        w_key_next;

    map_tile_decode u_decode (
        .i_tile      (ram_dout),
        .i_key_count (r_key_count),
        .o_evt       (w_evt),
        .o_accept    (w_accept),
        .o_do_write  (w_do_write),
        .o_key_delta (w_key_delta)
    );

    assign w_oob = (req_x >= 4'(MAP_WIDTH)) || (req_y >= 4'(MAP_HEIGHT));

    // Next key count: pickups saturate at 15, doors only decrement when a key is held.
    always_comb begin
        w_key_next = r_key_count;
        if (w_key_delta == 2'sd1) begin
            if (r_key_count != 4'd15) begin
                w_key_next = r_key_count + 4'd1;
            end else begin
                w_key_next = r_key_count;
            end
        end else if (w_key_delta == -2'sd1) begin
            w_key_next = r_key_count - 4'd1;
        end else begin
            w_key_next = r_key_count;
        end
    end

    // Request FSM with registered RAM and response outputs.
    always_ff @(posedge clk) begin
        if (sys_rst) begin
            r_state       <= S_IDLE;
            r_req_x       <= 4'd0;
            r_req_y       <= 4'd0;
            r_evt         <= EVT_FLOOR;
            r_accept      <= 1'b0;
            r_ram_addr    <= 19'd0;
            r_ram_we      <= 1'b0;
            r_ram_din     <= 16'd0;
            r_resp_valid  <= 1'b0;
            r_resp_accept <= 1'b0;
            r_resp_x      <= 4'd0;
            r_resp_y      <= 4'd0;
            r_resp_evt    <= EVT_FLOOR;
            r_stair_pulse <= 1'b0;
            r_key_count   <= 4'd0;
            r_req_ready   <= 1'b1;
        end else begin
            r_resp_valid  <= 1'b0;
            r_stair_pulse <= 1'b0;
            r_ram_we      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_req_x     <= req_x;
                        r_req_y     <= req_y;
                        r_req_ready <= 1'b0;
                        if (w_oob) begin
                            r_state       <= S_RESP;
                            r_resp_valid  <= 1'b1;
                            r_resp_accept <= 1'b0;
                            r_resp_evt    <= EVT_BLOCKED;
                            r_resp_x      <= req_x;
                            r_resp_y      <= req_y;
                        end else begin
                            r_ram_addr <= map_addr(req_x, req_y);
                            r_state    <= S_ADDR;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_ADDR: begin
                    r_state <= S_DATA;
                end
                S_DATA: begin
                    r_evt    <= w_evt;
                    r_accept <= w_accept;
                    if (w_do_write) begin
                        r_key_count <= w_key_next;
                        r_ram_we    <= 1'b1;
                        r_ram_din   <= TILE_FLOOR;
                        r_state     <= S_WRITE;
                    end else begin
                        r_resp_valid  <= 1'b1;
                        r_resp_accept <= w_accept;
                        r_resp_evt    <= w_evt;
                        r_resp_x      <= r_req_x;
                        r_resp_y      <= r_req_y;
                        r_stair_pulse <= (w_evt == EVT_STAIR);
                        r_state       <= S_RESP;
                    end
                end
                S_WRITE: begin
                    r_resp_valid  <= 1'b1;
                    r_resp_accept <= r_accept;
                    r_resp_evt    <= r_evt;
                    r_resp_x      <= r_req_x;
                    r_resp_y      <= r_req_y;
                    r_state       <= S_RESP;
                end
                S_RESP: begin
                    r_req_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_req_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    // Reset gates the write strobe so a write in flight never lands.
    assign ram_we      = r_ram_we & ~sys_rst;
    assign ram_addr    = r_ram_addr;
    assign ram_din     = r_ram_din;
    assign req_ready   = r_req_ready;
    assign resp_valid  = r_resp_valid;
    assign resp_accept = r_resp_accept;
    assign resp_x      = r_resp_x;
    assign resp_y      = r_resp_y;
    assign resp_evt    = r_resp_evt;
    assign stair_pulse = r_stair_pulse;
    assign key_count   = r_key_count;

endmodule

// File: tb/tb_map_event_unit.sv
// Directed bench for map_event_unit with a behavioural 1-cycle-latency map RAM.
module tb_map_event_unit;
    import map_event_unit_pkg::*;

    logic        clk = 1'b0;
    logic        sys_rst, req_valid, req_ready, ram_we;
    logic [3:0]  req_x, req_y, resp_x, resp_y, key_count;
    logic [18:0] ram_addr;
    logic [15:0] ram_din, ram_dout;
    logic        resp_valid, resp_accept, stair_pulse;
    logic [2:0]  resp_evt;

    logic [15:0] mem [0:127];
    int we_cnt = 0;
    int resp_cnt = 0;
    int n_assert = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    map_event_unit dut (
        .clk(clk), .sys_rst(sys_rst), .req_valid(req_valid), .req_x(req_x), .req_y(req_y),
        .req_ready(req_ready), .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din),
        .ram_dout(ram_dout), .resp_valid(resp_valid), .resp_accept(resp_accept),
        .resp_x(resp_x), .resp_y(resp_y), .resp_evt(resp_evt), .stair_pulse(stair_pulse),
        .key_count(key_count)
    );

    always @(posedge clk) begin
        ram_dout <= mem[ram_addr[6:0]];
        if (ram_we) mem[ram_addr[6:0]] = ram_din;
    end

    always @(posedge clk) begin
        if (ram_we) we_cnt <= we_cnt + 1;
        if (resp_valid) resp_cnt <= resp_cnt + 1;
    end

    function automatic int idx(input int x, input int y);
        return y * 11 + x;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Presents one request for a single cycle; returns in cycle 1.
    task automatic issue(input logic [3:0] x, input logic [3:0] y);
        req_x = x;
        req_y = y;
        req_valid = 1'b1;
        tick;
        req_valid = 1'b0;
    endtask

    task automatic run_req(input logic [3:0] x, input logic [3:0] y);
        issue(x, y);
        for (int i = 0; i < 12; i++) begin
            if (resp_valid) break;
            tick;
        end
        chk("resp_seen", 32'(resp_valid), 32'd1);
        tick;
    endtask

    int a_save, w_save, r_save;

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = TILE_FLOOR;
        mem[idx(0, 0)] = TILE_WALL;
        mem[idx(2, 0)] = TILE_DOOR;
        mem[idx(1, 1)] = TILE_KEY;
        mem[idx(4, 1)] = TILE_KEY;
        mem[idx(5, 5)] = TILE_STAIR;
        mem[idx(8, 8)] = TILE_KEY;
        mem[idx(9, 9)] = 16'h0BAD;
        for (int x = 0; x < 11; x++) mem[idx(x, 6)] = TILE_KEY;
        for (int x = 0; x < 4; x++) mem[idx(x, 7)] = TILE_KEY;

        sys_rst = 1'b1; req_valid = 1'b0; req_x = 4'd0; req_y = 4'd0;
        tick; tick;
        sys_rst = 1'b0;
        tick;
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_we", 32'(ram_we), 32'd0);
        chk("rst_addr", 32'(ram_addr), 32'd0);
        chk("rst_din", 32'(ram_din), 32'd0);
        chk("rst_resp", {resp_valid, resp_accept, stair_pulse, resp_evt, resp_x, resp_y}, 32'd0);
        chk("rst_keys", 32'(key_count), 32'd0);

        // Request during reset is ignored.
        sys_rst = 1'b1; req_valid = 1'b1; req_x = 4'd3; req_y = 4'd4;
        tick;
        sys_rst = 1'b0; req_valid = 1'b0;
        tick; tick;
        chk("rstreq_addr", 32'(ram_addr), 32'd0);
        chk("rstreq_ready", 32'(req_ready), 32'd1);
        chk("rstreq_resp", 32'(resp_cnt), 32'd0);

        // Floor at (3,4).
        issue(4'd3, 4'd4);
        chk("floor_addr_c1", 32'(ram_addr), 32'd47);
        chk("floor_ready_c1", 32'(req_ready), 32'd0);
        tick;
        chk("floor_rv_c2", 32'(resp_valid), 32'd0);
        tick;
        chk("floor_rv_c3", 32'(resp_valid), 32'd1);
        chk("floor_acc", 32'(resp_accept), 32'd1);
        chk("floor_evt", 32'(resp_evt), 32'd0);
        chk("floor_xy", {resp_x, resp_y}, 32'h34);
        chk("floor_stair", 32'(stair_pulse), 32'd0);
        tick;
        chk("floor_rv_c4", 32'(resp_valid), 32'd0);
        chk("floor_ready_c4", 32'(req_ready), 32'd1);
        chk("floor_hold_x", 32'(resp_x), 32'd3);
        chk("floor_no_we", 32'(we_cnt), 32'd0);

        // Locked door at (2,0).
        issue(4'd2, 4'd0);
        tick; tick;
        chk("lock_rv", 32'(resp_valid), 32'd1);
        chk("lock_evt", 32'(resp_evt), 32'd4);
        chk("lock_acc", 32'(resp_accept), 32'd0);
        tick;
        chk("lock_no_we", 32'(we_cnt), 32'd0);
        chk("lock_tile", 32'(mem[2]), 32'(TILE_DOOR));

        // Key at (1,1).
        issue(4'd1, 4'd1);
        tick; tick;
        chk("key_we_c3", 32'(ram_we), 32'd1);
        chk("key_addr", 32'(ram_addr), 32'd12);
        chk("key_din", 32'(ram_din), 32'(TILE_FLOOR));
        chk("key_cnt_c3", 32'(key_count), 32'd1);
        chk("key_rv_c3", 32'(resp_valid), 32'd0);
        tick;
        chk("key_rv_c4", 32'(resp_valid), 32'd1);
        chk("key_acc", 32'(resp_accept), 32'd1);
        chk("key_evt", 32'(resp_evt), 32'd2);
        chk("key_we_c4", 32'(ram_we), 32'd0);
        tick;
        chk("key_cleared", 32'(mem[12]), 32'(TILE_FLOOR));
        chk("key_we_once", 32'(we_cnt), 32'd1);

        run_req(4'd4, 4'd1);
        chk("key2_cnt", 32'(key_count), 32'd2);

        // Door at (2,0) opened with two keys.
        issue(4'd2, 4'd0);
        tick; tick;
        chk("door_we", 32'(ram_we), 32'd1);
        chk("door_addr", 32'(ram_addr), 32'd2);
        chk("door_cnt", 32'(key_count), 32'd1);
        tick;
        chk("door_rv", 32'(resp_valid), 32'd1);
        chk("door_evt", 32'(resp_evt), 32'd3);
        chk("door_acc", 32'(resp_accept), 32'd0);
        chk("door_xy", {resp_x, resp_y}, 32'h20);
        tick;
        chk("door_cleared", 32'(mem[2]), 32'(TILE_FLOOR));

        // Collect keys up to 15, then one more to check saturation.
        for (int x = 0; x < 11; x++) run_req(4'(x), 4'd6);
        for (int x = 0; x < 3; x++) run_req(4'(x), 4'd7);
        chk("keys_full", 32'(key_count), 32'd15);
        issue(4'd3, 4'd7);
        tick; tick;
        chk("sat_we", 32'(ram_we), 32'd1);
        chk("sat_cnt", 32'(key_count), 32'd15);
        tick;
        chk("sat_evt", 32'(resp_evt), 32'd2);
        tick;
        chk("sat_cleared", 32'(mem[idx(3, 7)]), 32'(TILE_FLOOR));

        // Out-of-bounds requests.
        a_save = 32'(ram_addr); w_save = we_cnt;
        issue(4'd11, 4'd0);
        chk("oobx_rv_c1", 32'(resp_valid), 32'd1);
        chk("oobx_evt", 32'(resp_evt), 32'd1);
        chk("oobx_acc", 32'(resp_accept), 32'd0);
        chk("oobx_xy", {resp_x, resp_y}, 32'hB0);
        tick;
        chk("oobx_rv_c2", 32'(resp_valid), 32'd0);
        chk("oobx_ready", 32'(req_ready), 32'd1);
        issue(4'd0, 4'd15);
        chk("ooby_rv_c1", 32'(resp_valid), 32'd1);
        chk("ooby_evt", 32'(resp_evt), 32'd1);
        chk("ooby_y", 32'(resp_y), 32'd15);
        tick;
        chk("oob_addr_same", 32'(ram_addr), 32'(a_save));
        chk("oob_no_we", 32'(we_cnt), 32'(w_save));

        // Wall and an unlisted tile ID are both blocked.
        issue(4'd0, 4'd0);
        tick; tick;
        chk("wall_rv", 32'(resp_valid), 32'd1);
        chk("wall_evt", 32'(resp_evt), 32'd1);
        chk("wall_acc", 32'(resp_accept), 32'd0);
        tick;
        issue(4'd9, 4'd9);
        tick; tick;
        chk("unk_evt", 32'(resp_evt), 32'd1);
        chk("unk_acc", 32'(resp_accept), 32'd0);
        tick;

        // Stair with a second request ignored during ADDR.
        r_save = resp_cnt;
        issue(4'd5, 4'd5);
        req_x = 4'd3; req_y = 4'd4; req_valid = 1'b1;
        tick;
        req_valid = 1'b0;
        chk("stair_rv_c2", 32'(resp_valid), 32'd0);
        tick;
        chk("stair_rv_c3", 32'(resp_valid), 32'd1);
        chk("stair_pulse", 32'(stair_pulse), 32'd1);
        chk("stair_acc", 32'(resp_accept), 32'd1);
        chk("stair_evt", 32'(resp_evt), 32'd5);
        chk("stair_xy", {resp_x, resp_y}, 32'h55);
        tick;
        chk("stair_pulse_c4", {resp_valid, stair_pulse}, 32'd0);
        for (int i = 0; i < 6; i++) tick;
        chk("stair_one_resp", 32'(resp_cnt - r_save), 32'd1);

        // Reset during the write cycle of a key pickup at (8,8).
        r_save = resp_cnt; w_save = we_cnt;
        issue(4'd8, 4'd8);
        tick; tick;
        chk("abort_we_c3", 32'(ram_we), 32'd1);
        sys_rst = 1'b1;
        #1;
        chk("abort_we_gated", 32'(ram_we), 32'd0);
        @(posedge clk); #1;
        sys_rst = 1'b0;
        chk("abort_we_after", 32'(ram_we), 32'd0);
        chk("abort_keys", 32'(key_count), 32'd0);
        chk("abort_ready", 32'(req_ready), 32'd1);
        chk("abort_rv", 32'(resp_valid), 32'd0);
        for (int i = 0; i < 4; i++) tick;
        chk("abort_no_resp", 32'(resp_cnt - r_save), 32'd0);
        chk("abort_no_we", 32'(we_cnt - w_save), 32'd0);
        chk("abort_tile", 32'(mem[idx(8, 8)]), 32'(TILE_KEY));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/map_event_unit.md
# map_event_unit

Resolves player move requests against the tile map. It sits between the player movement logic and port B of the map block RAM. For each requested target cell it reads the tile, decides accept or reject, updates the key inventory, and writes back a floor tile when an item is consumed or a door is opened. The movement logic receives a single-cycle response carrying the destination and an event code.

## Interface
- MAP_WIDTH, 11: map columns; valid x is 0..MAP_WIDTH-1
- MAP_HEIGHT, 11: map rows; valid y is 0..MAP_HEIGHT-1
- TILE_FLOOR / TILE_WALL / TILE_KEY / TILE_DOOR / TILE_STAIR, resource-table values: 16-bit tile IDs
- clk  in  1  logic clock
- sys_rst  in  1  synchronous, active-high reset
- req_valid  in  1  move request strobe
- req_x, req_y  in  4 each  requested target cell
- req_ready  out  1  high only in IDLE
- ram_addr  out  19  map address, equal to y*MAP_WIDTH+x; registered
- ram_we  out  1  write enable; registered
- ram_din  out  16  write data; registered
- ram_dout  in  16  read data; synchronous RAM, 1-cycle latency
- resp_valid  out  1  one-cycle response pulse
- resp_accept  out  1  player may move to resp_x/resp_y
- resp_x, resp_y  out  4 each  echo of the request cell
- resp_evt  out  3  0 FLOOR, 1 BLOCKED, 2 KEY, 3 DOOR_OPEN, 4 DOOR_LOCKED, 5 STAIR
- stair_pulse  out  1  one-cycle pulse, coincident with resp_valid for STAIR
- key_count  out  4  keys held; saturates at 15

## Operation
- FSM states: IDLE, ADDR, DATA, WRITE, RESP.
- IDLE
  - On req_valid, latch req_x and req_y.
  - Out of bounds (x>=MAP_WIDTH or y>=MAP_HEIGHT): go to RESP with BLOCKED. No RAM access.
  - Otherwise: drive ram_addr and go to ADDR.
- ADDR: wait one cycle for the RAM read.
- DATA: sample ram_dout and classify the tile.
  - FLOOR: accept.
  - STAIR: accept; stair_pulse fires in RESP.
  - KEY: accept; key_count+1, saturating at 15; go to WRITE.
  - DOOR with key_count>0: reject, player stays; key_count-1; go to WRITE.
  - DOOR with key_count==0: DOOR_LOCKED; reject; no write.
  - WALL or any unlisted ID: BLOCKED; reject.
- WRITE: ram_we=1 for exactly one cycle; ram_din=TILE_FLOOR; ram_addr unchanged. Then go to RESP.
- RESP: resp_valid=1 for one cycle. Then go to IDLE.
- Address arithmetic:
  - Computed in 19 bits; no wrap is possible given the bounds check.
  - Multiply by the constant MAP_WIDTH.
- Requests arriving outside IDLE are ignored and not queued. The requester must hold req_valid or re-issue.
- resp_* fields hold their last values after resp_valid drops. Only resp_valid marks new data.

## Timing
- Reset values: state IDLE, req_ready=1, ram_we=0, ram_addr=0, ram_din=0, resp_valid=0, resp_accept=0, resp_x=resp_y=0, resp_evt=0, stair_pulse=0, key_count=0.
- Cycle 0 is the edge that accepts the request. resp_valid is high:
  - cycle 1 for out-of-bounds;
  - cycle 3 for FLOOR, STAIR, BLOCKED, DOOR_LOCKED;
  - cycle 4 for KEY and DOOR_OPEN, with ram_we in cycle 3.
- key_count is updated on the DATA→WRITE edge, so it is visible in the WRITE cycle.
- Throughput: one request per 2–5 cycles. req_ready returns the cycle after RESP.
- sys_rst wins in any state at the next edge:
  - ram_we drops immediately, so an in-flight write is aborted and the tile is left unchanged;
  - no resp_valid is issued;
  - key_count clears.
- req_valid asserted together with sys_rst is ignored.

## Structure
- Shared parameter file holds the tile IDs (from the resource table), event codes, state encoding, and MAP_WIDTH/MAP_HEIGHT.
- Sub-module map_tile_decode: purely combinational.
  - Inputs: tile, key_count.
  - Outputs: evt, accept, do_write, key_delta (+1/0/-1).
  - Kept separate so new tile types (monsters, potions) extend only that file.

## Test plan
- Floor at (3,4), MAP_WIDTH=11, req_valid 1 cycle → ram_addr=47 in cycle 1; resp_valid in cycle 3 with accept=1, evt=0, resp=(3,4); ram_we never asserted.
- Key at (1,1), key_count=0 → ram_we=1, addr=12, din=TILE_FLOOR in cycle 3; key_count=1; resp in cycle 4, accept=1, evt=2. Repeat with key_count=15 → count stays 15, tile still cleared.
- Door at (2,0): with key_count=0 → evt=4, accept=0, no write. With key_count=2 → evt=3, accept=0, key_count=1, addr 2 written with floor.
- Request (11,0) and request (0,15) → resp_valid in cycle 1, evt=1, accept=0; no RAM access.
- Stair tile → stair_pulse and resp_valid high in the same single cycle, accept=1. Second req_valid during ADDR → ignored; exactly one response.
- sys_rst asserted in the WRITE cycle of a key pickup → ram_we low at the next edge, state IDLE, key_count=0, no resp_valid; map cell retains TILE_KEY.
